// File: rtl/icache_bank_pkg.sv
// Shared types and sizing helpers for the instruction-cache bank responder.
package icache_bank_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Width of a word index into a bank of the given depth
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Address bits consumed by bank selection; a single bank selects nothing
  function automatic int bank_bits(input int n_banks);
    return (n_banks > 1) ? $clog2(n_banks) : 0;
  endfunction

endpackage

// File: rtl/icache_bank_sram.sv
// Single-port instruction SRAM: one read or one write per cycle, registered read data.
module icache_bank_sram
  import icache_bank_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = index_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register only moves on a read, so it holds the last word returned
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (en && !we) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/icache_bank_responder.sv
// Bank-side instruction fetch responder: zero sweep after reset, fill-priority
// arbitration onto a single-port SRAM, and a fixed-latency response pipeline.
module icache_bank_responder
  import icache_bank_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int UID_WIDTH     = 8,
  parameter int N_CACHE_BANKS = 16,
  parameter int DEPTH         = 256,
  parameter int LATENCY       = 1,
  parameter int OFFSET        = $clog2(DATA_WIDTH) - 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     request_i,
  input  logic [ADDRESS_WIDTH-1:0] address_i,
  input  logic [UID_WIDTH-1:0]     UID_i,
  output logic                     grant_o,
  output logic                     response_o,
  output logic [DATA_WIDTH-1:0]    read_data_o,
  output logic [UID_WIDTH-1:0]     response_UID_o,
  input  logic                     fill_req_i,
  input  logic [ADDRESS_WIDTH-1:0] fill_addr_i,
  input  logic [DATA_WIDTH-1:0]    fill_data_i,
  output logic                     fill_gnt_o,
  output logic                     init_done_o
);

  localparam int IDX_W = index_width(DEPTH);
  localparam int BB    = bank_bits(N_CACHE_BANKS);
  localparam int LSB   = OFFSET + BB;

  state_e                state_r;
  state_e                state_next_s;
  logic [IDX_W-1:0]      init_cnt_r;
  logic                  init_done_r;

  logic                  grant_s;
  logic                  fill_gnt_s;
  logic                  sram_en_s;
  logic                  sram_we_s;
  logic [IDX_W-1:0]      sram_addr_s;
  logic [DATA_WIDTH-1:0] sram_wdata_s;
  logic [DATA_WIDTH-1:0] sram_rdata_s;

  logic [IDX_W-1:0]      req_idx_s;
  logic [IDX_W-1:0]      fill_idx_s;
  logic                  unused_s;

  logic [LATENCY-1:0]    valid_r;
  logic [UID_WIDTH-1:0]  uid_r  [LATENCY];
  logic [DATA_WIDTH-1:0] data_r [LATENCY];

  // Bits above the bank index and below the word offset only alias
  assign req_idx_s  = address_i[LSB +: IDX_W];
  assign fill_idx_s = fill_addr_i[LSB +: IDX_W];
  assign unused_s   = ^{address_i, fill_addr_i};

  // State register, sweep counter and registered init-done flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= INIT;
      init_cnt_r  <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      init_done_r <= (state_next_s == READY);
      if (state_r == INIT) begin
        init_cnt_r <= init_cnt_r + IDX_W'(1);
      end
    end
  end

  // Next state, fill-first arbitration and SRAM port steering
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    fill_gnt_s   = 1'b0;
    sram_en_s    = 1'b0;
    sram_we_s    = 1'b0;
    sram_addr_s  = init_cnt_r;
    sram_wdata_s = '0;
    case (state_r)
      INIT: begin
        sram_en_s   = 1'b1;
        sram_we_s   = 1'b1;
        sram_addr_s = init_cnt_r;
        if (init_cnt_r == IDX_W'(DEPTH - 1)) begin
          state_next_s = READY;
        end else begin
          state_next_s = INIT;
        end
      end
      READY: begin
        state_next_s = READY;
        if (rst_i) begin
          sram_en_s = 1'b0;
        end else if (fill_req_i) begin
          fill_gnt_s   = 1'b1;
          sram_en_s    = 1'b1;
          sram_we_s    = 1'b1;
          sram_addr_s  = fill_idx_s;
          sram_wdata_s = fill_data_i;
        end else if (request_i) begin
          grant_s     = 1'b1;
          sram_en_s   = 1'b1;
          sram_we_s   = 1'b0;
          sram_addr_s = req_idx_s;
        end else begin
          sram_en_s = 1'b0;
        end
      end
      default: begin
        state_next_s = INIT;
      end
    endcase
  end

  icache_bank_sram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (sram_en_s),
    .we    (sram_we_s),
    .addr  (sram_addr_s),
    .wdata (sram_wdata_s),
    .rdata (sram_rdata_s)
  );

  // Response pipeline; stage 0 pairs with the SRAM read register for its data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        uid_r[k]  <= '0;
        data_r[k] <= '0;
      end
    end else begin
      valid_r[0] <= grant_s;
      if (grant_s) begin
        uid_r[0] <= UID_i;
      end
      for (int k = 1; k < LATENCY; k++) begin
        valid_r[k] <= valid_r[k-1];
        if (valid_r[k-1]) begin
          uid_r[k]  <= uid_r[k-1];
          data_r[k] <= (k == 1) ? sram_rdata_s : data_r[k-1];
        end
      end
    end
  end

  assign grant_o        = grant_s;
  assign fill_gnt_o     = fill_gnt_s;
  assign init_done_o    = init_done_r;
  assign response_o     = valid_r[LATENCY-1];
  assign response_UID_o = uid_r[LATENCY-1];
  assign read_data_o    = (LATENCY == 1) ? sram_rdata_s : data_r[LATENCY-1];

endmodule

// File: tb/tb_icache_bank_responder.sv
// Randomised scoreboard bench for icache_bank_responder, run at latencies 1 and 3
// side by side against a word-array reference model.
module tb_icache_bank_responder;

  localparam int DEPTH = 256;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [7:0]  uid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        request_i;
  logic [31:0] address_i;
  logic [7:0]  UID_i;
  logic        fill_req_i;
  logic [31:0] fill_addr_i;
  logic [31:0] fill_data_i;

  logic        grant     [2];
  logic        fill_gnt  [2];
  logic        resp      [2];
  logic        init_done [2];
  logic [31:0] rdata     [2];
  logic [7:0]  ruid      [2];

  exp_t        exp_q [2][$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_d [2];
  logic [7:0]  last_u [2];
  int          cyc, nvec, nerr, icnt;
  bit          ready_m, mon_en;

  always #5 clk = ~clk;

  icache_bank_responder #(.LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst_i), .request_i(request_i), .address_i(address_i),
    .UID_i(UID_i), .grant_o(grant[0]), .response_o(resp[0]),
    .read_data_o(rdata[0]), .response_UID_o(ruid[0]), .fill_req_i(fill_req_i),
    .fill_addr_i(fill_addr_i), .fill_data_i(fill_data_i),
    .fill_gnt_o(fill_gnt[0]), .init_done_o(init_done[0])
  );

  icache_bank_responder #(.LATENCY(3)) dut_l3 (
    .clk_i(clk), .rst_i(rst_i), .request_i(request_i), .address_i(address_i),
    .UID_i(UID_i), .grant_o(grant[1]), .response_o(resp[1]),
    .read_data_o(rdata[1]), .response_UID_o(ruid[1]), .fill_req_i(fill_req_i),
    .fill_addr_i(fill_addr_i), .fill_data_i(fill_data_i),
    .fill_gnt_o(fill_gnt[1]), .init_done_o(init_done[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // 4-byte words and 16 banks: skip 6 address bits, keep 256 words, drop the rest
  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd64) % 32'd256);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, check arbitration outputs, then advance the model
  task automatic step(input bit rst, input bit req, input logic [31:0] addr,
                      input logic [7:0] uid, input bit freq,
                      input logic [31:0] faddr, input logic [31:0] fdata);
    bit eg, efg;
    exp_t e;
    rst_i = rst; request_i = req; address_i = addr; UID_i = uid;
    fill_req_i = freq; fill_addr_i = faddr; fill_data_i = fdata;
    efg = ready_m && !rst && freq;
    eg  = ready_m && !rst && req && !freq;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("grant_o[L%0d]", lat_of(d)), grant[d], eg);
      check($sformatf("fill_gnt_o[L%0d]", lat_of(d)), fill_gnt[d], efg);
      check($sformatf("init_done_o[L%0d]", lat_of(d)), init_done[d], ready_m);
    end
    @(posedge clk);
    if (rst) begin
      ready_m = 1'b0;
      icnt = 0;
      for (int d = 0; d < 2; d++) begin
        exp_q[d].delete();
        last_d[d] = '0;
        last_u[d] = '0;
      end
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (!ready_m) begin
      icnt++;
      if (icnt == DEPTH) ready_m = 1'b1;
    end else if (efg) begin
      model_mem[idx_of(faddr)] = fdata;
    end else if (eg) begin
      for (int d = 0; d < 2; d++) begin
        e.due = cyc + lat_of(d);
        e.data = model_mem[idx_of(addr)];
        e.uid = uid;
        exp_q[d].push_back(e);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] uid);
    step(1'b0, 1'b1, addr, uid, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic fill(input logic [31:0] addr, input logic [31:0] data);
    step(1'b0, 1'b0, 32'h0, 8'h0, 1'b1, addr, data);
  endtask

  // Scoreboard monitor: every response must match the oldest due entry
  always @(negedge clk) begin
    bit   due_now;
    exp_t e;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        due_now = (exp_q[d].size() > 0) && (exp_q[d][0].due == cyc);
        check($sformatf("response_o[L%0d]", lat_of(d)), resp[d], due_now);
        if (due_now) begin
          e = exp_q[d].pop_front();
          if (resp[d] === 1'b1) begin
            check($sformatf("read_data_o[L%0d]", lat_of(d)), rdata[d], e.data);
            check($sformatf("response_UID_o[L%0d]", lat_of(d)), ruid[d], e.uid);
          end
          last_d[d] = e.data;
          last_u[d] = e.uid;
        end else begin
          check($sformatf("hold_data[L%0d]", lat_of(d)), rdata[d], last_d[d]);
          check($sformatf("hold_uid[L%0d]", lat_of(d)), ruid[d], last_u[d]);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    rst_i = 1'b1; request_i = 1'b0; address_i = '0; UID_i = '0;
    fill_req_i = 1'b0; fill_addr_i = '0; fill_data_i = '0;
    cyc = 0; nvec = 0; nerr = 0; icnt = 0; ready_m = 1'b0; mon_en = 1'b0;
    for (int d = 0; d < 2; d++) begin last_d[d] = '0; last_u[d] = '0; end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Sweep with a request held high: no grant until the 257th cycle
    step(1'b1, 1'b1, 32'h40, 8'h01, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 260; i++) rd(32'h40, 8'($urandom));
    idle(3);

    fill(32'h0, 32'hDEADBEEF);
    rd(32'h0, 8'h04);
    idle(3);

    // Fill holds off a concurrent read for three cycles
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0, 8'h10, 1'b1, 32'h80, $urandom);
    rd(32'h0, 8'h10);
    rd(32'h80, 8'h11);
    idle(3);

    rd(32'h0, 8'h01); rd(32'h80, 8'h02); rd(32'h40, 8'h04); rd(32'h0, 8'h08);
    idle(4);

    fill(32'h0000_0040, 32'h11);
    rd(32'h0000_4040, 8'h20);
    idle(3);

    // Reset with reads in flight; filled words must come back zero
    rd(32'h0, 8'h40);
    rd(32'h40, 8'h80);
    step(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 258; i++) rd(32'h0, 8'h03);
    rd(32'h40, 8'h05);
    rd(32'h80, 8'h06);
    idle(4);

    // Random traffic over a small index pool so fills and reads collide
    for (int i = 0; i < 900; i++) begin
      a = ($urandom & 32'hFFFF_C03F) | (32'(($urandom_range(0, 7) * 37) % 256) << 6);
      if ($urandom_range(0, 399) == 0) begin
        step(1'b1, 1'b1, a, 8'($urandom), 1'b0, 32'h0, 32'h0);
      end else begin
        step(1'b0, ($urandom_range(0, 9) < 6), a, 8'($urandom),
             ($urandom_range(0, 9) < 3),
             ($urandom & 32'hFFFF_C03F) | (32'(($urandom_range(0, 7) * 37) % 256) << 6),
             $urandom);
      end
    end
    idle(6);

    for (int d = 0; d < 2; d++) begin
      check($sformatf("drained[L%0d]", lat_of(d)), 64'(exp_q[d].size()), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
